seq_signed_divider: RTL and testbench

- Multi-cycle signed divider. It is the inverse companion of the team's 8x8 sequential signed multiplier.
- Takes a 16-bit signed dividend (a multiplier Product) and an 8-bit signed divisor. Returns a 16-bit signed quotient and an 8-bit signed remainder.
- Uses a restoring shift-subtract loop on magnitudes, one quotient bit per clock.
- Same start/ready handshake as the multiplier, so both units share one arithmetic controller.

---
 rtl/seq_signed_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_signed_divider.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed divider, 16-bit dividend / 8-bit divisor.
// Restoring shift-subtract on magnitudes, one quotient bit per clock, then a sign fix-up.
// Shares the start/ready handshake of the 8x8 sequential signed multiplier.
// Optional macro SEQ_DIVIDER_ZERO_CHECK_EN: detect a zero divisor, skip the loop and
// return a saturated quotient with div_by_zero set.
//
// Handshake: start is a one-cycle request. Dividend/Divisor are sampled on the rising
// edge where start=1 and ready=1 (state IDLE or DONE). ready drops on that edge and rises
// again together with valid Quotient/Remainder. start seen while ready=0 is ignored.
module seq_signed_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] Dividend,
    input  logic [VW-1:0] Divisor,
    output logic [DW-1:0] Quotient,
    output logic [VW-1:0] Remainder,
    output logic          ready,
    output logic          div_by_zero,
    output logic [1:0]    dbg_state_o
);

    localparam int CW = $clog2(DW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;      // dividend magnitude; quotient bits shift in at the LSB
    logic [VW:0]   dvs_q, dvs_d;      // divisor magnitude, one extra bit so |-128| fits
    logic [VW:0]   rem_q, rem_d;      // partial remainder magnitude
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sd_q, sd_d;        // dividend sign
    logic          sv_q, sv_d;        // divisor sign
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] remo_q, remo_d;
    logic          ready_q, ready_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    logic          zero_q, zero_d;    // current operation has a zero divisor
    logic          dbz_q, dbz_d;
`endif

    // Operand magnitudes at the sampling edge
    logic [DW-1:0] dvd_abs;
    logic [VW:0]   dvs_ext;
    logic [VW:0]   dvs_abs;

    // One restoring iteration
    logic [VW:0]   shifted;
    logic [VW+1:0] diff;
    logic          q_bit;

    assign dvd_abs = Dividend[DW-1] ? -Dividend : Dividend;
    assign dvs_ext = {Divisor[VW-1], Divisor};
    assign dvs_abs = Divisor[VW-1] ? -dvs_ext : dvs_ext;

    // Partial remainder stays below the divisor magnitude (<=128), so its low VW bits
    // plus the incoming dividend bit always hold the shifted value.
    assign shifted = {rem_q[VW-1:0], dvd_q[DW-1]};
    assign diff    = {1'b0, shifted} - {1'b0, dvs_q};
    assign q_bit   = ~diff[VW+1];

    // Next-state and datapath for the handshake, the divide loop and the sign fix-up
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        ready_d = ready_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
        zero_d  = zero_q;
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = dvd_abs;
                    dvs_d   = dvs_abs;
                    rem_d   = '0;
                    cnt_d   = CW'(DW - 1);
                    sd_d    = Dividend[DW-1];
                    sv_d    = Divisor[VW-1];
                    ready_d = 1'b0;
                    state_d = CALC;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                    dbz_d   = 1'b0;
                    zero_d  = (Divisor == '0);
                    // Keep the raw low dividend byte; it becomes the remainder.
                    if (Divisor == '0) rem_d = {1'b0, Dividend[VW-1:0]};
`endif
                end
            end
            CALC: begin
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                if (zero_q) state_d = FIX;
                else
`endif
                begin
                    rem_d = q_bit ? diff[VW:0] : shifted;
                    dvd_d = {dvd_q[DW-2:0], q_bit};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = FIX;
                end
            end
            FIX: begin
                // -32768 / -1 gives magnitude 32768, which wraps to 16'h8000 here.
                quot_d  = (sd_q ^ sv_q) ? -dvd_q : dvd_q;
                remo_d  = sd_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                if (zero_q) begin
                    quot_d = sd_q ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                    remo_d = rem_q[VW-1:0];
                end
                dbz_d   = zero_q;
`endif
                ready_d = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            ready_q <= 1'b1;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            ready_q <= ready_d;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign Quotient    = quot_q;
    assign Remainder   = remo_q;
    assign ready       = ready_q;
    assign dbg_state_o = state_q;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed sign/edge cases, busy handshake, mid-operation
// reset, zero divisor (both builds of SEQ_DIVIDER_ZERO_CHECK_EN) and back-to-back random ops.
module tb_seq_signed_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        ready;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] exp_q[$];

  seq_signed_divider #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one request for exactly one rising edge; caller sits just after an edge
  task automatic drive_start(input logic [15:0] dd, input logic [7:0] vv);
    start = 1'b1;
    Dividend = dd;
    Divisor = vv;
    @(posedge clk);
    #1;
    start = 1'b0;
    Dividend = 16'($urandom);
    Divisor = 8'($urandom);
  endtask

  // monitor: count edges until ready is seen high, bounded by max_n
  task automatic wait_ready(input int max_n, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ready !== 1'b1 && n < max_n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    Dividend = '0;
    Divisor = '0;
    #12;
    tests_run++;
    if ({Quotient, Remainder, ready, div_by_zero, dbg_state} !== {16'h0, 8'h0, 1'b1, 1'b0, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset: Q=%h R=%h ready=%b dbz=%b state=%0d, want Q=0 R=0 ready=1 dbz=0 state=0",
               Quotient, Remainder, ready, div_by_zero, dbg_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_signs();
    int dd[4] = '{1000, -1000, 1000, -1000};
    int vv[4] = '{7, 7, -7, -7};
    int eq[4] = '{142, -142, -142, 142};
    int er[4] = '{6, -6, 6, -6};
    int n;
    logic [23:0] e;
    for (int i = 0; i < 4; i++) begin
      drive_start(16'(dd[i]), 8'(vv[i]));
      exp_q.push_back({16'(eq[i]), 8'(er[i])});
      wait_ready(40, n);
      tests_run++;
      if (n !== 17) begin
        tests_failed++;
        $display("FAIL sign_latency[%0d]: ready after %0d clocks, want 17", i, n);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      tests_run++;
      if ({Quotient, Remainder} !== e) begin
        tests_failed++;
        $display("FAIL sign_result %0d/%0d: Q=%h R=%h, want Q=%h R=%h",
                 dd[i], vv[i], Quotient, Remainder, e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_edges();
    int dd[3] = '{-32768, 1000, 0};
    int vv[3] = '{-1, -128, 5};
    int eq[3] = '{32'h8000, -7, 0};
    int er[3] = '{0, 104, 0};
    int n;
    logic [23:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_start(16'(dd[i]), 8'(vv[i]));
      exp_q.push_back({16'(eq[i]), 8'(er[i])});
      wait_ready(40, n);
      tests_run++;
      if (n !== 17) begin
        tests_failed++;
        $display("FAIL edge_latency[%0d]: ready after %0d clocks, want 17", i, n);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      tests_run++;
      if ({Quotient, Remainder, div_by_zero} !== {e, 1'b0}) begin
        tests_failed++;
        $display("FAIL edge_result %0d/%0d: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=0",
                 dd[i], vv[i], Quotient, Remainder, div_by_zero, e[23:8], e[7:0]);
      end
    end
  endtask

  task automatic test_busy();
    int n;
    logic [23:0] e;
    drive_start(16'd3000, 8'd9);
    exp_q.push_back({16'd333, 8'd3});
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    // second request lands on clock 5, while the unit is busy
    drive_start(16'd50, 8'd5);
    wait_ready(40, n);
    tests_run++;
    if (n !== 12) begin
      tests_failed++;
      $display("FAIL busy_latency: ready %0d clocks after the ignored start, want 12", n);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    tests_run++;
    if ({Quotient, Remainder} !== e) begin
      tests_failed++;
      $display("FAIL busy_result: Q=%h R=%h, want Q=%h R=%h", Quotient, Remainder, e[23:8], e[7:0]);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if ({ready, dbg_state, Quotient} !== {1'b1, 2'd3, 16'd333}) begin
      tests_failed++;
      $display("FAIL busy_no_restart: ready=%b state=%0d Q=%h, want ready=1 state=3 Q=014d",
               ready, dbg_state, Quotient);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [23:0] e;
    drive_start(16'd3000, 8'd9);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_busy: ready=%b at clock 8, want 0", ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({Quotient, Remainder, ready, dbg_state} !== {16'h0, 8'h0, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL midrst_outputs: Q=%h R=%h ready=%b state=%0d, want Q=0 R=0 ready=1 state=0",
               Quotient, Remainder, ready, dbg_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_start(16'd100, 8'd10);
    exp_q.push_back({16'd10, 8'd0});
    wait_ready(40, n);
    tests_run++;
    if (n !== 17) begin
      tests_failed++;
      $display("FAIL midrst_latency: ready after %0d clocks, want 17", n);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    tests_run++;
    if ({Quotient, Remainder} !== e) begin
      tests_failed++;
      $display("FAIL midrst_result: Q=%h R=%h, want Q=%h R=%h", Quotient, Remainder, e[23:8], e[7:0]);
    end
  endtask

  task automatic test_zero();
    int n;
    logic [23:0] e;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    drive_start(16'd500, 8'd0);
    wait_ready(40, n);
    tests_run++;
    if ({n, div_by_zero, Quotient, Remainder} !== {32'd2, 1'b1, 16'h7FFF, 8'hF4}) begin
      tests_failed++;
      $display("FAIL zero_pos: clocks=%0d dbz=%b Q=%h R=%h, want clocks=2 dbz=1 Q=7fff R=f4",
               n, div_by_zero, Quotient, Remainder);
    end
    drive_start(-16'sd500, 8'd0);
    wait_ready(40, n);
    tests_run++;
    if ({n, div_by_zero, Quotient, Remainder} !== {32'd2, 1'b1, 16'h8000, 8'h0C}) begin
      tests_failed++;
      $display("FAIL zero_neg: clocks=%0d dbz=%b Q=%h R=%h, want clocks=2 dbz=1 Q=8000 R=0c",
               n, div_by_zero, Quotient, Remainder);
    end
    drive_start(16'd10, 8'd3);
    exp_q.push_back({16'd3, 8'd1});
    tests_run++;
    if (div_by_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_clear: dbz=%b after accepted start, want 0", div_by_zero);
    end
    wait_ready(40, n);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    tests_run++;
    if ({n, div_by_zero, Quotient, Remainder} !== {32'd17, 1'b0, e}) begin
      tests_failed++;
      $display("FAIL zero_next: clocks=%0d dbz=%b Q=%h R=%h, want clocks=17 dbz=0 Q=%h R=%h",
               n, div_by_zero, Quotient, Remainder, e[23:8], e[7:0]);
    end
`else
    drive_start(16'd500, 8'd0);
    wait_ready(40, n);
    tests_run++;
    if ({n, div_by_zero} !== {32'd17, 1'b0}) begin
      tests_failed++;
      $display("FAIL zero_nocheck: clocks=%0d dbz=%b, want clocks=17 dbz=0", n, div_by_zero);
    end
    e = '0;
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    int a;
    int b;
    logic [15:0] dd;
    logic [7:0] vv;
    logic [15:0] prev_q;
    logic [23:0] e;
    for (int i = 0; i < 12; i++) begin
      dd = 16'($urandom_range(0, 65535));
      if (i == 0) dd = 16'h8000;
      vv = 8'($urandom_range(1, 255));
      if (i == 1) vv = 8'h80;
      a = int'($signed(dd));
      b = int'($signed(vv));
      prev_q = Quotient;
      drive_start(dd, vv);
      exp_q.push_back({16'(a / b), 8'(a % b)});
      tests_run++;
      if ({Quotient, ready} !== {prev_q, 1'b0}) begin
        tests_failed++;
        $display("FAIL b2b_hold[%0d]: Q=%h ready=%b after start, want Q=%h ready=0", i, Quotient, ready, prev_q);
      end
      wait_ready(40, n);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      tests_run++;
      if ({n, Quotient, Remainder} !== {32'd17, e}) begin
        tests_failed++;
        $display("FAIL b2b_result %0d/%0d: clocks=%0d Q=%h R=%h, want clocks=17 Q=%h R=%h",
                 a, b, n, Quotient, Remainder, e[23:8], e[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_edges();
    test_busy();
    test_mid_reset();
    test_zero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
